ex_bu_pipe: RTL and testbench

EX_BU_PIPE -- requirements
Module: ex_bu_pipe

---
 rtl/ex_bu_pipe.sv | 163 ++++++++++++++++
 tb/tb_ex_bu_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_bu_pipe.sv
// Branch-unit execute pipe: one operand stage (S1) resolving branches, followed by
// a DEPTH-entry result FIFO that feeds writeback.
module ex_bu_pipe #(
    parameter int XLEN   = 32,
    parameter int PTAG_W = 6,
    parameter int CW_W   = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              EX_en,
    output logic              EX_ready,
    input  logic [OP_W-1:0]   EX_Operation,
    input  logic [XLEN-1:0]   EX_imm,
    input  logic [XLEN-1:0]   EX_Src1,
    input  logic [XLEN-1:0]   EX_Src2,
    input  logic [XLEN-1:0]   EX_PC,
    input  logic [XLEN-1:0]   EX_Pred_PC,
    input  logic [PTAG_W-1:0] EX_Phydst,
    input  logic [CW_W-1:0]   EX_Commit_Window,
    output logic              WB_valid,
    input  logic              WB_ready,
    output logic              WB_Branch,
    output logic              WB_Reserve,
    output logic              WB_Mispredict,
    output logic [XLEN-1:0]   WB_Branch_PC,
    output logic [XLEN-1:0]   WB_Reserve_PC,
    output logic [PTAG_W-1:0] WB_Phydst,
    output logic [CW_W-1:0]   WB_Commit_Window
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = OP_W'(0),  OP_BEQ  = OP_W'(1),  OP_BNE  = OP_W'(2),
        OP_BLEZ = OP_W'(3),  OP_BGTZ = OP_W'(4),  OP_BLTZ = OP_W'(5),
        OP_BGEZ = OP_W'(6),  OP_J    = OP_W'(7),  OP_JAL  = OP_W'(8),
        OP_JR   = OP_W'(9),  OP_JALR = OP_W'(10)
    } op_e;

    typedef struct packed {
        logic              branch;
        logic              reserve;
        logic              mispredict;
        logic [XLEN-1:0]   branch_pc;
        logic [XLEN-1:0]   reserve_pc;
        logic [PTAG_W-1:0] phydst;
        logic [CW_W-1:0]   cw;
    } res_t;

    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic [XLEN-1:0]   s1_imm, s1_src1, s1_src2, s1_pc, s1_pred;
    logic [PTAG_W-1:0] s1_phydst;
    logic [CW_W-1:0]   s1_cw;

    res_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;

    logic              issue, push, pop;
    logic              taken, link, src1_neg, src1_zero;
    logic [XLEN-1:0]   pc4, pc8, br_tgt, j_tgt, tgt, next_pc;
    res_t              res;

    // S1 is counted as occupied so its unconditional push always finds room
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
    assign EX_ready  = (occupancy < (CNT_W + 1)'(DEPTH));
    assign issue     = EX_en && EX_ready;
    assign push      = s1_valid;
    assign pop       = (count != '0) && WB_ready;

    assign pc4       = s1_pc + XLEN'(4);
    assign pc8       = s1_pc + XLEN'(8);
    assign br_tgt    = pc4 + (s1_imm << 2);
    assign j_tgt     = {pc4[XLEN-1:28], s1_imm[25:0], 2'b00};
    assign src1_neg  = s1_src1[XLEN-1];
    assign src1_zero = (s1_src1 == '0);

    always_comb begin
        taken = 1'b0;
        link  = 1'b0;
        tgt   = br_tgt;
        case (s1_op)
            OP_BEQ:  taken = (s1_src1 == s1_src2);
            OP_BNE:  taken = (s1_src1 != s1_src2);
            OP_BLEZ: taken = src1_neg || src1_zero;
            OP_BGTZ: taken = !src1_neg && !src1_zero;
            OP_BLTZ: taken = src1_neg;
            OP_BGEZ: taken = !src1_neg;
            OP_J:    begin taken = 1'b1; tgt = j_tgt; end
            OP_JAL:  begin taken = 1'b1; tgt = j_tgt; link = 1'b1; end
            OP_JR:   begin taken = 1'b1; tgt = s1_src1; end
            OP_JALR: begin taken = 1'b1; tgt = s1_src1; link = 1'b1; end
            default: ;
        endcase
        next_pc        = taken ? tgt : pc8;
        res.branch     = taken;
        res.reserve    = link;
        res.mispredict = (next_pc != s1_pred);
        res.branch_pc  = next_pc;
        res.reserve_pc = pc8;
        res.phydst     = s1_phydst;
        res.cw         = s1_cw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_imm    <= '0;
            s1_src1   <= '0;
            s1_src2   <= '0;
            s1_pc     <= '0;
            s1_pred   <= '0;
            s1_phydst <= '0;
            s1_cw     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_op     <= EX_Operation;
                s1_imm    <= EX_imm;
                s1_src1   <= EX_Src1;
                s1_src2   <= EX_Src2;
                s1_pc     <= EX_PC;
                s1_pred   <= EX_Pred_PC;
                s1_phydst <= EX_Phydst;
                s1_cw     <= EX_Commit_Window;
            end
            if (push) begin
                mem[wr_ptr] <= res;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign WB_valid         = (count != '0);
    assign WB_Branch        = mem[rd_ptr].branch;
    assign WB_Reserve       = mem[rd_ptr].reserve;
    assign WB_Mispredict    = mem[rd_ptr].mispredict;
    assign WB_Branch_PC     = mem[rd_ptr].branch_pc;
    assign WB_Reserve_PC    = mem[rd_ptr].reserve_pc;
    assign WB_Phydst        = mem[rd_ptr].phydst;
    assign WB_Commit_Window = mem[rd_ptr].cw;
endmodule

// File: tb/tb_ex_bu_pipe.sv
// Scoreboarded bench for ex_bu_pipe: accepted issues are modelled and queued,
// writeback pops are compared in order.
module tb_ex_bu_pipe;
    localparam int XLEN = 32, PTAG_W = 6, CW_W = 4, OP_W = 6, DEPTH = 4;

    logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic              EX_en = 1'b0, EX_ready, WB_valid, WB_ready = 1'b0;
    logic [OP_W-1:0]   EX_Operation = '0;
    logic [XLEN-1:0]   EX_imm = '0, EX_Src1 = '0, EX_Src2 = '0, EX_PC = '0, EX_Pred_PC = '0;
    logic [PTAG_W-1:0] EX_Phydst = '0, WB_Phydst;
    logic [CW_W-1:0]   EX_Commit_Window = '0, WB_Commit_Window;
    logic              WB_Branch, WB_Reserve, WB_Mispredict;
    logic [XLEN-1:0]   WB_Branch_PC, WB_Reserve_PC;

    typedef struct packed {
        logic        br;
        logic        rsv;
        logic        mis;
        logic [31:0] bpc;
        logic [31:0] rpc;
        logic [5:0]  tag;
        logic [3:0]  cw;
    } exp_t;

    exp_t q[$];
    exp_t act;
    int   n_checks = 0, n_pass = 0;

    ex_bu_pipe #(.XLEN(XLEN), .PTAG_W(PTAG_W), .CW_W(CW_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .EX_en(EX_en), .EX_ready(EX_ready), .EX_Operation(EX_Operation),
        .EX_imm(EX_imm), .EX_Src1(EX_Src1), .EX_Src2(EX_Src2), .EX_PC(EX_PC),
        .EX_Pred_PC(EX_Pred_PC), .EX_Phydst(EX_Phydst), .EX_Commit_Window(EX_Commit_Window),
        .WB_valid(WB_valid), .WB_ready(WB_ready), .WB_Branch(WB_Branch),
        .WB_Reserve(WB_Reserve), .WB_Mispredict(WB_Mispredict),
        .WB_Branch_PC(WB_Branch_PC), .WB_Reserve_PC(WB_Reserve_PC),
        .WB_Phydst(WB_Phydst), .WB_Commit_Window(WB_Commit_Window)
    );

    always #5 clk = ~clk;

    assign act = '{WB_Branch, WB_Reserve, WB_Mispredict, WB_Branch_PC, WB_Reserve_PC,
                   WB_Phydst, WB_Commit_Window};

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] imm, a, b, pc, pred,
                                   input logic [5:0] tag, input logic [3:0] cw);
        logic tk, lk;
        logic [31:0] p4, tgt, nxt;
        tk  = 1'b0;
        lk  = 1'b0;
        p4  = pc + 32'd4;
        tgt = p4 + {imm[29:0], 2'b00};
        case (op)
            6'd1:  tk = (a == b);
            6'd2:  tk = (a != b);
            6'd3:  tk = ($signed(a) <= 0);
            6'd4:  tk = ($signed(a) > 0);
            6'd5:  tk = ($signed(a) < 0);
            6'd6:  tk = ($signed(a) >= 0);
            6'd7, 6'd8: begin tk = 1'b1; tgt = {p4[31:28], imm[25:0], 2'b00}; lk = (op == 6'd8); end
            6'd9, 6'd10: begin tk = 1'b1; tgt = a; lk = (op == 6'd10); end
            default: ;
        endcase
        nxt = tk ? tgt : pc + 32'd8;
        return '{tk, lk, (nxt != pred), nxt, pc + 32'd8, tag, cw};
    endfunction

    // Scoreboard: pops compared first, then the accepted issue of this cycle is queued
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (WB_valid && WB_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL wb_unexpected: got %h, expected no result", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e)
                        $display("FAIL wb_result: got br=%0b rsv=%0b mis=%0b bpc=%h rpc=%h tag=%0d cw=%0d, expected br=%0b rsv=%0b mis=%0b bpc=%h rpc=%h tag=%0d cw=%0d",
                                 act.br, act.rsv, act.mis, act.bpc, act.rpc, act.tag, act.cw,
                                 e.br, e.rsv, e.mis, e.bpc, e.rpc, e.tag, e.cw);
                    else n_pass++;
                end
            end
            if (EX_en && EX_ready)
                q.push_back(model(EX_Operation, EX_imm, EX_Src1, EX_Src2, EX_PC, EX_Pred_PC,
                                  EX_Phydst, EX_Commit_Window));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] imm, a, b, pc, pred,
                             input logic [5:0] tag, input logic [3:0] cw);
        EX_en = 1'b1; EX_Operation = op; EX_imm = imm; EX_Src1 = a; EX_Src2 = b;
        EX_PC = pc; EX_Pred_PC = pred; EX_Phydst = tag; EX_Commit_Window = cw;
    endtask

    task automatic rand_issue();
        logic [31:0] a, b, pc, imm, pred;
        a   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        b   = ($urandom_range(0, 1) == 0) ? a : $urandom;
        pc  = {$urandom, 2'b00};
        imm = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
        case ($urandom_range(0, 2))
            0:       pred = pc + 32'd8;
            1:       pred = pc + 32'd4 + {imm[29:0], 2'b00};
            default: pred = $urandom;
        endcase
        set_issue(6'($urandom_range(0, 15)), imm, a, b, pc, pred, 6'($urandom), 4'($urandom));
    endtask

    task automatic drain();
        int cyc = 0;
        EX_en = 1'b0;
        WB_ready = 1'b1;
        while ((q.size() != 0 || WB_valid) && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (q.size() != 0 || WB_valid)
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({WB_valid, WB_Branch, WB_Reserve, WB_Mispredict, WB_Branch_PC, WB_Reserve_PC,
             WB_Phydst, WB_Commit_Window} !== '0)
            $display("FAIL reset_outputs: got valid=%0b bpc=%h rpc=%h, expected all 0",
                     WB_valid, WB_Branch_PC, WB_Reserve_PC);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({EX_ready, WB_valid} !== 2'b10)
            $display("FAIL reset_release: got ready=%0b valid=%0b, expected ready=1 valid=0", EX_ready, WB_valid);
        else n_pass++;
    endtask

    task automatic test_beq();
        WB_ready = 1'b1;
        set_issue(6'd1, 32'h10, 32'd5, 32'd5, 32'h100, 32'h108, 6'd3, 4'd2);
        tick();
        EX_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (WB_valid !== 1'b0) $display("FAIL beq_latency: got valid=%0b, expected 0", WB_valid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({WB_valid, WB_Branch, WB_Mispredict, WB_Branch_PC} !== {3'b111, 32'h144})
            $display("FAIL beq_result: got valid=%0b br=%0b mis=%0b bpc=%h, expected 1 1 1 00000144",
                     WB_valid, WB_Branch, WB_Mispredict, WB_Branch_PC);
        else n_pass++;
        drain();
    endtask

    task automatic test_jal();
        WB_ready = 1'b1;
        set_issue(6'd8, 32'h40, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 6'd9, 4'd5);
        tick();
        EX_en = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({WB_valid, WB_Reserve, WB_Branch_PC, WB_Reserve_PC, WB_Phydst} !==
            {2'b11, 32'h0000_0100, 32'h0040_0008, 6'd9})
            $display("FAIL jal_result: got valid=%0b rsv=%0b bpc=%h rpc=%h tag=%0d, expected 1 1 00000100 00400008 9",
                     WB_valid, WB_Reserve, WB_Branch_PC, WB_Reserve_PC, WB_Phydst);
        else n_pass++;
        drain();
    endtask

    task automatic test_bgtz_negative();
        WB_ready = 1'b1;
        set_issue(6'd4, 32'h7, 32'h8000_0000, 32'h0, 32'h200, 32'h208, 6'd1, 4'd1);
        tick();
        EX_en = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({WB_valid, WB_Branch, WB_Mispredict, WB_Branch_PC} !== {3'b100, 32'h208})
            $display("FAIL bgtz_neg: got valid=%0b br=%0b mis=%0b bpc=%h, expected 1 0 0 00000208",
                     WB_valid, WB_Branch, WB_Mispredict, WB_Branch_PC);
        else n_pass++;
        drain();
    endtask

    task automatic test_all_ops();
        WB_ready = 1'b1;
        for (int op = 0; op < 16; op++) begin
            set_issue(6'(op), 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1234, 32'h9000_1000,
                      32'h9000_1008, 6'(op), 4'(op));
            tick();
        end
        for (int i = 0; i < 80; i++) begin
            WB_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) rand_issue();
            else EX_en = 1'b0;
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        WB_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            rand_issue();
            @(negedge clk);
            if (EX_ready) acc++;
            if (WB_valid && q.size() > 0) begin
                n_checks++;
                if (act !== q[0]) $display("FAIL head_stable: got %h, expected %h", act, q[0]);
                else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (acc !== DEPTH || EX_ready !== 1'b0)
            $display("FAIL bp_accept: got accepted=%0d ready=%0b, expected %0d 0", acc, EX_ready, DEPTH);
        else n_pass++;
        drain();
        @(negedge clk);
        n_checks++;
        if (EX_ready !== 1'b1) $display("FAIL bp_ready_back: got %0b, expected 1", EX_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        WB_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_issue();
            @(negedge clk);
            if (EX_ready) acc++;
            tick();
        end
        n_checks++;
        if (acc !== 20) $display("FAIL back_to_back: got %0d accepted, expected 20", acc);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        int seen = 0;
        WB_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_issue();
            tick();
        end
        rand_issue();
        flush = 1'b1;
        WB_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (WB_valid !== 1'b1) $display("FAIL flush_precond: got valid=%0b, expected 1", WB_valid);
        else n_pass++;
        tick();
        flush = 1'b0;
        EX_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({WB_valid, EX_ready} !== 2'b01)
            $display("FAIL flush_clear: got valid=%0b ready=%0b, expected 0 1", WB_valid, EX_ready);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (WB_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL flush_stale: got %0d stale cycles, expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        WB_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_issue();
            tick();
        end
        EX_en = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (WB_valid !== 1'b1) $display("FAIL areset_precond: got valid=%0b, expected 1", WB_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if ({WB_valid, WB_Branch_PC} !== {1'b0, 32'h0})
            $display("FAIL areset_async: got valid=%0b bpc=%h, expected 0 00000000", WB_valid, WB_Branch_PC);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({EX_ready, WB_valid} !== 2'b10)
            $display("FAIL areset_release: got ready=%0b valid=%0b, expected 1 0", EX_ready, WB_valid);
        else n_pass++;
        tick();
        set_issue(6'd9, 32'h0, 32'hDEAD_BEE0, 32'h0, 32'h300, 32'hDEAD_BEE0, 6'd4, 4'd7);
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_jal();
        test_bgtz_negative();
        test_all_ops();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
